image_adjust_stage: RTL

Per-pixel adjustment stage between the BMP image reader and the BMP image writer. It accepts one even/odd RGB888 pixel pair per qualified cycle and applies one of four operations: pass-through, saturating brighten, saturating darken, or grey threshold. It drives the writer's `hsync` and `DATA_WRITE_*` inputs through a fixed 2-cycle pipeline. It also counts pairs per frame and flags the last pair of each frame.

---
 rtl/image_adjust_stage.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/image_adjust_stage.sv
// -----------------------------------------------------------------------------
// image_adjust_stage
//
// Per-pixel adjustment stage between the BMP image reader and the BMP image
// writer. One even/odd RGB888 pixel pair is accepted per cycle with vld_in=1
// and passes through a fixed two-register pipeline. Each pair gets one of:
// pass-through, saturating brighten, saturating darken or grey threshold.
// The operation is latched at the first pair of every frame.
//
// Ports:
//   HCLK                  clock, rising edge
//   HRESET                asynchronous active-high reset
//   mode[1:0]             0 pass, 1 brighten, 2 darken, 3 threshold
//   vld_in                input pair valid (no backpressure)
//   DATA_{R,G,B}0/1       even / odd input pixel, 8 bits per channel
//   hsync                 output pair valid, two cycles after vld_in
//   DATA_WRITE_{R,G,B}0/1 processed even / odd pixel, held during bubbles
//   frame_done            one-cycle pulse with the hsync of a frame's last pair
// -----------------------------------------------------------------------------
module image_adjust_stage #(
    parameter int WIDTH     = 768,
    parameter int HEIGHT    = 512,
    parameter int VALUE     = 100,
    parameter int THRESHOLD = 90
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic [1:0] mode,
    input  logic       vld_in,
    input  logic [7:0] DATA_R0,
    input  logic [7:0] DATA_G0,
    input  logic [7:0] DATA_B0,
    input  logic [7:0] DATA_R1,
    input  logic [7:0] DATA_G1,
    input  logic [7:0] DATA_B1,
    output logic       hsync,
    output logic [7:0] DATA_WRITE_R0,
    output logic [7:0] DATA_WRITE_G0,
    output logic [7:0] DATA_WRITE_B0,
    output logic [7:0] DATA_WRITE_R1,
    output logic [7:0] DATA_WRITE_G1,
    output logic [7:0] DATA_WRITE_B1,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_BRIGHT = 2'd1,
        MODE_DARK   = 2'd2,
        MODE_THRESH = 2'd3
    } mode_e;

    localparam int PAIRS = (WIDTH * HEIGHT) / 2;
    localparam int CNT_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(PAIRS - 1);
    localparam logic [8:0] VALUE_9   = 9'(VALUE);
    // Grey limit compared against the 10-bit channel sum (avoids a divide by 3).
    localparam logic [9:0] THR_LIMIT = 10'(3 * THRESHOLD);

    // Brighten: the 9th bit of the sum is the overflow that saturates to 255.
    function automatic logic [7:0] sat_add(input logic [7:0] c);
        logic [8:0] s;
        s = {1'b0, c} + VALUE_9;
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // Darken: a borrow out of bit 8 means the result went negative.
    function automatic logic [7:0] sat_sub(input logic [7:0] c);
        logic [8:0] d;
        d = {1'b0, c} - VALUE_9;
        return d[8] ? 8'h00 : d[7:0];
    endfunction

    function automatic logic [7:0] adjust_chan(input logic [7:0] c,
                                               input mode_e      m,
                                               input logic       grey_hit);
        logic [7:0] r;
        case (m)
            MODE_PASS:   r = c;
            MODE_BRIGHT: r = sat_add(c);
            MODE_DARK:   r = sat_sub(c);
            MODE_THRESH: r = grey_hit ? 8'hFF : 8'h00;
            default:     r = c;
        endcase
        return r;
    endfunction

    logic [CNT_W-1:0] pair_cnt_r;
    mode_e            mode_q_r;
    mode_e            eff_mode_s;
    logic             is_first_s;
    logic             is_last_s;
    logic [9:0]       sum0_s;
    logic [9:0]       sum1_s;

    logic             s1_vld_r;
    logic             s1_last_r;
    mode_e            s1_mode_r;
    logic [7:0]       s1_px_r [6];
    logic [9:0]       s1_sum0_r;
    logic [9:0]       s1_sum1_r;

    logic [7:0]       out_px_s [6];
    logic             hit0_s;
    logic             hit1_s;

    // Frame position decode and the mode used by the incoming pair.
    always_comb begin
        is_first_s = (pair_cnt_r == {CNT_W{1'b0}});
        is_last_s  = (pair_cnt_r == LAST_PAIR);
        if (is_first_s) begin
            eff_mode_s = mode_e'(mode);
        end else begin
            eff_mode_s = mode_q_r;
        end
        sum0_s = {2'b00, DATA_R0} + {2'b00, DATA_G0} + {2'b00, DATA_B0};
        sum1_s = {2'b00, DATA_R1} + {2'b00, DATA_G1} + {2'b00, DATA_B1};
    end

    // Pair counter and per-frame mode latch; only HRESET clears them.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            pair_cnt_r <= {CNT_W{1'b0}};
            mode_q_r   <= MODE_PASS;
        end else if (vld_in) begin
            if (is_last_s) begin
                pair_cnt_r <= {CNT_W{1'b0}};
            end else begin
                pair_cnt_r <= pair_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (is_first_s) begin
                mode_q_r <= mode_e'(mode);
            end else begin
                mode_q_r <= mode_q_r;
            end
        end else begin
            pair_cnt_r <= pair_cnt_r;
            mode_q_r   <= mode_q_r;
        end
    end

    // Stage 1: capture the pair, its frame position, mode and channel sums.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            s1_vld_r  <= 1'b0;
            s1_last_r <= 1'b0;
            s1_mode_r <= MODE_PASS;
            s1_sum0_r <= 10'd0;
            s1_sum1_r <= 10'd0;
            for (int i = 0; i < 6; i++) begin
                s1_px_r[i] <= 8'd0;
            end
        end else begin
            s1_vld_r <= vld_in;
            if (vld_in) begin
                s1_last_r  <= is_last_s;
                s1_mode_r  <= eff_mode_s;
                s1_sum0_r  <= sum0_s;
                s1_sum1_r  <= sum1_s;
                s1_px_r[0] <= DATA_R0;
                s1_px_r[1] <= DATA_G0;
                s1_px_r[2] <= DATA_B0;
                s1_px_r[3] <= DATA_R1;
                s1_px_r[4] <= DATA_G1;
                s1_px_r[5] <= DATA_B1;
            end else begin
                s1_last_r <= s1_last_r;
                s1_mode_r <= s1_mode_r;
                s1_sum0_r <= s1_sum0_r;
                s1_sum1_r <= s1_sum1_r;
                s1_px_r   <= s1_px_r;
            end
        end
    end

    // Stage 2 combinational operation; each pixel is thresholded on its own sum.
    always_comb begin
        hit0_s = (s1_sum0_r > THR_LIMIT);
        hit1_s = (s1_sum1_r > THR_LIMIT);
        for (int i = 0; i < 3; i++) begin
            out_px_s[i]     = adjust_chan(s1_px_r[i],     s1_mode_r, hit0_s);
            out_px_s[i + 3] = adjust_chan(s1_px_r[i + 3], s1_mode_r, hit1_s);
        end
    end

    // Output registers; data only updates for a valid stage-1 pair.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            hsync         <= 1'b0;
            frame_done    <= 1'b0;
            DATA_WRITE_R0 <= 8'd0;
            DATA_WRITE_G0 <= 8'd0;
            DATA_WRITE_B0 <= 8'd0;
            DATA_WRITE_R1 <= 8'd0;
            DATA_WRITE_G1 <= 8'd0;
            DATA_WRITE_B1 <= 8'd0;
        end else begin
            hsync      <= s1_vld_r;
            frame_done <= s1_vld_r & s1_last_r;
            if (s1_vld_r) begin
                DATA_WRITE_R0 <= out_px_s[0];
                DATA_WRITE_G0 <= out_px_s[1];
                DATA_WRITE_B0 <= out_px_s[2];
                DATA_WRITE_R1 <= out_px_s[3];
                DATA_WRITE_G1 <= out_px_s[4];
                DATA_WRITE_B1 <= out_px_s[5];
            end else begin
                DATA_WRITE_R0 <= DATA_WRITE_R0;
                DATA_WRITE_G0 <= DATA_WRITE_G0;
                DATA_WRITE_B0 <= DATA_WRITE_B0;
                DATA_WRITE_R1 <= DATA_WRITE_R1;
                DATA_WRITE_G1 <= DATA_WRITE_G1;
                DATA_WRITE_B1 <= DATA_WRITE_B1;
            end
        end
    end

endmodule
